// File: rtl/d_search_pkg.sv
// Shared definitions for the modular-inverse search controller:
// state encoding and default operand widths.
package d_search_pkg;

    // Default exponent width; d, L and candidate are twice this wide.
    localparam int SIZE_DEF = 4;
    localparam int E_W      = SIZE_DEF;
    localparam int D_W      = 2 * SIZE_DEF;
    localparam int P_W      = 3 * SIZE_DEF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FOUND = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    // Width of the full cand*e product for a given exponent width.
    function automatic int prod_width(input int sz);
        return 3 * sz;
    endfunction

endpackage

// File: rtl/d_mod_check.sv
// Combinational test of one candidate: match when (cand * e) mod L == 1.
// The product is formed at full width so no high bits are lost.
module d_mod_check
    import d_search_pkg::*;
#(
    parameter int size = SIZE_DEF
) (
    input  logic [2*size-1:0] i_cand,
    input  logic [size-1:0]   i_e,
    input  logic [2*size-1:0] i_L,
    output logic              o_match
);

    localparam int W_P = prod_width(size);

    logic [W_P-1:0] w_prod;
    logic [W_P-1:0] w_rem;

    // Full-width product, remainder, and comparison against one.
    always_comb begin
        w_prod  = W_P'(i_cand) * W_P'(i_e);
        w_rem   = (i_L != '0) ? (w_prod % W_P'(i_L)) : '0;
        o_match = (i_L != '0) && (w_rem == W_P'(1));
    end

endmodule

// File: rtl/d_search_ctrl.sv
// Sequential search for d with (d * e) mod L == 1, one candidate per cycle.
// Optional feature: define D_SEARCH_STATS_EN to add the iter_cnt output,
// which reports how many candidates the last search examined.
module d_search_ctrl
    import d_search_pkg::*;
#(
    parameter int size = SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [size-1:0]   e,
    input  logic [2*size-1:0] L,
    output logic              busy,
    output logic              done,
    output logic              fail,
`ifdef D_SEARCH_STATS_EN
    output logic [2*size-1:0] iter_cnt,
`endif
    output logic [2*size-1:0] d_out
);

    localparam int W_E = size;
    localparam int W_D = 2 * size;

    state_t         r_state;
    logic [W_D-1:0] r_cand;
    logic [W_E-1:0] r_e;
    logic [W_D-1:0] r_L;
    logic           w_match;
    logic           w_accept;
    logic           w_illegal;

    // A start is only honoured in IDLE; illegal operands skip the search.
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_illegal = (L < W_D'(2)) || (e == '0);

    d_mod_check #(
        .size (size)
    ) u_mod_check (
        .i_cand  (r_cand),
        .i_e     (r_e),
        .i_L     (r_L),
        .o_match (w_match)
    );

    // Operand capture; holds steady for the whole search.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_e <= e;
            r_L <= L;
        end
    end

    // Search FSM with registered busy/done/fail/d_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cand  <= '0;
            d_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        r_cand  <= W_D'(1);
                        r_state <= w_illegal ? S_FAIL : S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        d_out   <= r_cand;
                        r_state <= S_FOUND;
                    end else if (r_cand == r_L - W_D'(1)) begin
                        r_state <= S_FAIL;
                    end else begin
                        r_cand <= r_cand + W_D'(1);
                    end
                end
                S_FOUND: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    fail    <= 1'b1;
                    d_out   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef D_SEARCH_STATS_EN
    // Count CHECK cycles of the current search; cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (w_accept) begin
            iter_cnt <= '0;
        end else if (r_state == S_CHECK) begin
            iter_cnt <= iter_cnt + W_D'(1);
        end
    end
`endif

endmodule

// File: tb/tb_d_search_ctrl.sv
// Directed bench for d_search_ctrl: latency, result, fail paths, reset.
module tb_d_search_ctrl;

    localparam int SZ = 4;

    logic            clk;
    logic            rst;
    logic            start;
    logic [SZ-1:0]   e;
    logic [2*SZ-1:0] L;
    logic            busy;
    logic            done;
    logic            fail;
    logic [2*SZ-1:0] d_out;
`ifdef D_SEARCH_STATS_EN
    logic [2*SZ-1:0] iter_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    d_search_ctrl #(
        .size (SZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .e        (e),
        .L        (L),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
`ifdef D_SEARCH_STATS_EN
        .iter_cnt (iter_cnt),
`endif
        .d_out    (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    // Present a one-cycle start at the negedge; return just after the accepting edge.
    task automatic launch(input logic [SZ-1:0] ev, input logic [2*SZ-1:0] lv);
        @(negedge clk);
        start = 1'b1;
        e     = ev;
        L     = lv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the accepting edge until done or fail (bounded).
    task automatic wait_result(input int n0, output int n, output logic dn, output logic fl,
                               output logic bz, output logic both, output logic saw_dn);
        n = n0; dn = 1'b0; fl = 1'b0; bz = 1'b0; both = 1'b0; saw_dn = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done && fail) both = 1'b1;
            if (done) saw_dn = 1'b1;
            if (done || fail) begin
                dn = done; fl = fail; bz = busy;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [SZ-1:0] ev, input logic [2*SZ-1:0] lv,
                             input int exp_lat, input logic exp_done, input logic [2*SZ-1:0] exp_d);
        int   n;
        logic dn, fl, bz, both, sd;
        launch(ev, lv);
        chk({tag, ".busy_start"}, 32'(busy), 32'd1);
        wait_result(0, n, dn, fl, bz, both, sd);
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".done"}, 32'(dn), 32'(exp_done));
        chk({tag, ".fail"}, 32'(fl), 32'(!exp_done));
        chk({tag, ".d_out"}, 32'(d_out), 32'(exp_d));
        chk({tag, ".busy_pulse"}, 32'(bz), 32'd1);
        chk({tag, ".excl"}, 32'(both), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        chk({tag, ".pulse_after"}, 32'({done, fail}), 32'd0);
    endtask

    initial begin
        int   n;
        logic dn, fl, bz, both, sd;

        rst = 1'b1; start = 1'b0; e = '0; L = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy",  32'(busy),  32'd0);
        chk("reset.done",  32'(done),  32'd0);
        chk("reset.fail",  32'(fail),  32'd0);
        chk("reset.d_out", 32'(d_out), 32'd0);

        // start while in reset must be discarded
        start = 1'b1; e = 4'd3; L = 8'd20;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start.busy", 32'(busy), 32'd0);

        run_check("e3L20", 4'd3, 8'd20, 8, 1'b1, 8'd7);
`ifdef D_SEARCH_STATS_EN
        chk("e3L20.iter", 32'(iter_cnt), 32'd7);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("e3L20.hold", 32'(d_out), 32'd7);

        run_check("e7L40", 4'd7, 8'd40, 24, 1'b1, 8'd23);

        // reset during the 4th CHECK cycle
        launch(4'd3, 8'd20);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst.busy",  32'(busy),  32'd0);
        chk("midrst.done",  32'(done),  32'd0);
        chk("midrst.fail",  32'(fail),  32'd0);
        chk("midrst.d_out", 32'(d_out), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst.idle", 32'(busy), 32'd0);
        run_check("restart", 4'd3, 8'd20, 8, 1'b1, 8'd7);

        // start held with new operands mid-search is ignored
        launch(4'd3, 8'd20);
        start = 1'b1; e = 4'd5; L = 8'd12;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(3, n, dn, fl, bz, both, sd);
        chk("ignore.latency", 32'(n), 32'd8);
        chk("ignore.done",    32'(dn), 32'd1);
        chk("ignore.d_out",   32'(d_out), 32'd7);
`ifdef D_SEARCH_STATS_EN
        chk("ignore.iter", 32'(iter_cnt), 32'd7);
`endif
        repeat (2) @(posedge clk);

        // no inverse exists: search runs to L-1 and fails
        launch(4'd2, 8'd20);
        wait_result(0, n, dn, fl, bz, both, sd);
        chk("nodinv.latency", 32'(n),     32'd20);
        chk("nodinv.fail",    32'(fl),    32'd1);
        chk("nodinv.d_out",   32'(d_out), 32'd0);
        chk("nodinv.no_done", 32'(sd),    32'd0);
`ifdef D_SEARCH_STATS_EN
        chk("nodinv.iter", 32'(iter_cnt), 32'd19);
`endif
        repeat (2) @(posedge clk);

        // illegal operands fail on the next cycle
        run_check("L0", 4'd3, 8'd0, 1, 1'b0, 8'd0);
        run_check("L1", 4'd3, 8'd1, 1, 1'b0, 8'd0);
        run_check("e0", 4'd0, 8'd20, 1, 1'b0, 8'd0);
`ifdef D_SEARCH_STATS_EN
        chk("e0.iter", 32'(iter_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
